// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit MIPS pipeline: control-bundle width,
// bit positions inside the bundle, and the all-zero bubble control word.
package mips_pkg;

  localparam int CTRL_W = 9;

  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]}
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 3;
  localparam int CTRL_ALU_OP     = 0;
  localparam int ALU_OP_W        = 3;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side inputs, WB bypass inputs and EX-side outputs.
// The master drives the ID/WB side; the slave is the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int N      = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
);
  logic              id_valid_in;
  logic [N-1:0]      id_pc_in;
  logic [N-1:0]      id_rdata1_in;
  logic [N-1:0]      id_rdata2_in;
  logic [N-1:0]      id_imm_in;
  logic [4:0]        id_rs_in;
  logic [4:0]        id_rt_in;
  logic [4:0]        id_rd_in;
  logic [CTRL_W-1:0] id_ctrl_in;
  logic              flush_in;
  logic              wb_reg_write_in;
  logic [4:0]        wb_write_reg_in;
  logic [N-1:0]      wb_write_data_in;

  logic              ex_valid_out;
  logic [N-1:0]      ex_pc_out;
  logic [N-1:0]      ex_rdata1_out;
  logic [N-1:0]      ex_rdata2_out;
  logic [N-1:0]      ex_imm_out;
  logic [4:0]        ex_rs_out;
  logic [4:0]        ex_rt_out;
  logic [4:0]        ex_dest_out;
  logic [CTRL_W-1:0] ex_ctrl_out;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_count_out;

  modport master (
    output id_valid_in, id_pc_in, id_rdata1_in, id_rdata2_in, id_imm_in,
           id_rs_in, id_rt_in, id_rd_in, id_ctrl_in, flush_in,
           wb_reg_write_in, wb_write_reg_in, wb_write_data_in,
    input  ex_valid_out, ex_pc_out, ex_rdata1_out, ex_rdata2_out, ex_imm_out,
           ex_rs_out, ex_rt_out, ex_dest_out, ex_ctrl_out, stall_out,
           stall_count_out
  );

  modport slave (
    input  id_valid_in, id_pc_in, id_rdata1_in, id_rdata2_in, id_imm_in,
           id_rs_in, id_rt_in, id_rd_in, id_ctrl_in, flush_in,
           wb_reg_write_in, wb_write_reg_in, wb_write_data_in,
    output ex_valid_out, ex_pc_out, ex_rdata1_out, ex_rdata2_out, ex_imm_out,
           ex_rs_out, ex_rt_out, ex_dest_out, ex_ctrl_out, stall_out,
           stall_count_out
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID
// instruction forces a one-cycle stall unless a branch flush squashes ID.
module hazard_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_dest,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_flush,
  output logic       o_stall
);
  logic w_load_use;

  // $zero is never a real producer, so a load to it cannot create a hazard
  assign w_load_use = i_ex_valid & i_ex_mem_read & (i_ex_dest != 5'd0) & i_id_valid &
                      ((i_ex_dest == i_id_rs) | (i_ex_dest == i_id_rt));
  assign o_stall    = w_load_use & ~i_flush;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and a saturating
// stall-cycle counter. Optional WB->ID operand bypass under `WB_BYPASS_EN.
module id_ex_stage #(
  parameter int N      = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  import mips_pkg::*;

  logic              w_stall;
  logic [N-1:0]      w_op1, w_op2;
  logic [4:0]        w_dest;

  logic              r_vld_p1;
  logic [N-1:0]      r_pc_p1, r_rdata1_p1, r_rdata2_p1, r_imm_p1;
  logic [4:0]        r_rs_p1, r_rt_p1, r_dest_p1;
  logic [CTRL_W-1:0] r_ctrl_p1;
  logic [CNT_W-1:0]  r_stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  hazard_detect u_hazard (
    .i_ex_valid    (r_vld_p1),
    .i_ex_mem_read (r_ctrl_p1[CTRL_MEM_READ]),
    .i_ex_dest     (r_dest_p1),
    .i_id_valid    (bus.id_valid_in),
    .i_id_rs       (bus.id_rs_in),
    .i_id_rt       (bus.id_rt_in),
    .i_flush       (bus.flush_in),
    .o_stall       (w_stall)
  );

`ifdef WB_BYPASS_EN
  // Register file reads old data on a same-cycle write; forward the WB value
  assign w_op1 = (bus.wb_reg_write_in && bus.wb_write_reg_in != 5'd0 &&
                  bus.wb_write_reg_in == bus.id_rs_in) ? bus.wb_write_data_in : bus.id_rdata1_in;
  assign w_op2 = (bus.wb_reg_write_in && bus.wb_write_reg_in != 5'd0 &&
                  bus.wb_write_reg_in == bus.id_rt_in) ? bus.wb_write_data_in : bus.id_rdata2_in;
`else
  assign w_op1 = bus.id_rdata1_in;
  assign w_op2 = bus.id_rdata2_in;
`endif

  assign w_dest = bus.id_ctrl_in[CTRL_REG_DST] ? bus.id_rd_in : bus.id_rt_in;

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1    <= 1'b0;
      r_pc_p1     <= '0;
      r_rdata1_p1 <= '0;
      r_rdata2_p1 <= '0;
      r_imm_p1    <= '0;
      r_rs_p1     <= '0;
      r_rt_p1     <= '0;
      r_dest_p1   <= '0;
      r_ctrl_p1   <= BUBBLE_CTRL;
    end else if (bus.flush_in || w_stall) begin
      r_vld_p1    <= 1'b0;
      r_pc_p1     <= '0;
      r_rdata1_p1 <= '0;
      r_rdata2_p1 <= '0;
      r_imm_p1    <= '0;
      r_rs_p1     <= '0;
      r_rt_p1     <= '0;
      r_dest_p1   <= '0;
      r_ctrl_p1   <= BUBBLE_CTRL;
    end else begin
      r_vld_p1    <= bus.id_valid_in;
      r_pc_p1     <= bus.id_pc_in;
      r_rdata1_p1 <= w_op1;
      r_rdata2_p1 <= w_op2;
      r_imm_p1    <= bus.id_imm_in;
      r_rs_p1     <= bus.id_rs_in;
      r_rt_p1     <= bus.id_rt_in;
      r_dest_p1   <= w_dest;
      r_ctrl_p1   <= bus.id_valid_in ? bus.id_ctrl_in : BUBBLE_CTRL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign bus.ex_valid_out    = r_vld_p1;
  assign bus.ex_pc_out       = r_pc_p1;
  assign bus.ex_rdata1_out   = r_rdata1_p1;
  assign bus.ex_rdata2_out   = r_rdata2_p1;
  assign bus.ex_imm_out      = r_imm_p1;
  assign bus.ex_rs_out       = r_rs_p1;
  assign bus.ex_rt_out       = r_rt_p1;
  assign bus.ex_dest_out     = r_dest_p1;
  assign bus.ex_ctrl_out     = r_ctrl_p1;
  assign bus.stall_out       = w_stall;
  assign bus.stall_count_out = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; a second instance with a 3-bit
// stall counter exercises counter saturation.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.N(32), .CTRL_W(9), .CNT_W(16)) bus ();
  id_ex_stage_if #(.N(32), .CTRL_W(9), .CNT_W(3))  bus_s ();

  id_ex_stage #(.N(32), .CTRL_W(9), .CNT_W(16)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage #(.N(32), .CTRL_W(9), .CNT_W(3))  u_small (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.id_valid_in      = bus.id_valid_in;
  assign bus_s.id_pc_in         = bus.id_pc_in;
  assign bus_s.id_rdata1_in     = bus.id_rdata1_in;
  assign bus_s.id_rdata2_in     = bus.id_rdata2_in;
  assign bus_s.id_imm_in        = bus.id_imm_in;
  assign bus_s.id_rs_in         = bus.id_rs_in;
  assign bus_s.id_rt_in         = bus.id_rt_in;
  assign bus_s.id_rd_in         = bus.id_rd_in;
  assign bus_s.id_ctrl_in       = bus.id_ctrl_in;
  assign bus_s.flush_in         = bus.flush_in;
  assign bus_s.wb_reg_write_in  = bus.wb_reg_write_in;
  assign bus_s.wb_write_reg_in  = bus.wb_write_reg_in;
  assign bus_s.wb_write_data_in = bus.wb_write_data_in;

  typedef struct {
    logic        v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs, rt, dest;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t         sb[$];
  ex_t         m_ex;
  logic [15:0] exp_cnt;
  logic [2:0]  exp_cnt_s;
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [8:0] mk_ctrl(input logic rw, mr, mw, m2r, as, rdst,
                                         input logic [2:0] op);
    return {rw, mr, mw, m2r, as, rdst, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b.v = 1'b0; b.pc = '0; b.r1 = '0; b.r2 = '0; b.imm = '0;
    b.rs = '0; b.rt = '0; b.dest = '0; b.ctrl = '0;
    return b;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.ex_valid_out}, 32'd0);
    chk({tag, "_pc"},    bus.ex_pc_out, 32'd0);
    chk({tag, "_r1"},    bus.ex_rdata1_out, 32'd0);
    chk({tag, "_r2"},    bus.ex_rdata2_out, 32'd0);
    chk({tag, "_imm"},   bus.ex_imm_out, 32'd0);
    chk({tag, "_dest"},  {27'd0, bus.ex_dest_out}, 32'd0);
    chk({tag, "_ctrl"},  {23'd0, bus.ex_ctrl_out}, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall_out}, 32'd0);
    chk({tag, "_cnt"},   {16'd0, bus.stall_count_out}, 32'd0);
    chk({tag, "_cnt_s"}, {29'd0, bus_s.stall_count_out}, 32'd0);
  endtask

  // Drive one ID instruction, check stall, then check the EX register one edge later.
  task automatic step(input string tag, input logic v, input logic [31:0] pc, r1, r2, imm,
                      input logic [4:0] rs, rt, rd, input logic [8:0] ctrl, input logic fl,
                      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    logic lu, st;
    ex_t  e, got;
    bus.id_valid_in = v;  bus.id_pc_in = pc; bus.id_rdata1_in = r1; bus.id_rdata2_in = r2;
    bus.id_imm_in = imm;  bus.id_rs_in = rs; bus.id_rt_in = rt; bus.id_rd_in = rd;
    bus.id_ctrl_in = ctrl; bus.flush_in = fl;
    bus.wb_reg_write_in = wbw; bus.wb_write_reg_in = wbr; bus.wb_write_data_in = wbd;
    #1;
    lu = m_ex.v & m_ex.ctrl[7] & (m_ex.dest != 5'd0) & v & ((m_ex.dest == rs) | (m_ex.dest == rt));
    st = lu & ~fl;
    chk({tag, "_stall"}, {31'd0, bus.stall_out}, {31'd0, st});
    if (fl || st) e = bubble();
    else begin
      e.v = v; e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rs = rs; e.rt = rt;
      e.dest = ctrl[3] ? rd : rt;
      e.ctrl = v ? ctrl : 9'd0;
`ifdef WB_BYPASS_EN
      if (wbw && wbr != 5'd0 && wbr == rs) e.r1 = wbd;
      if (wbw && wbr != 5'd0 && wbr == rt) e.r2 = wbd;
`endif
    end
    sb.push_back(e);
    if (st) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt_s != 3'h7) exp_cnt_s = exp_cnt_s + 3'd1;
    end
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "_valid"}, {31'd0, bus.ex_valid_out}, {31'd0, got.v});
    chk({tag, "_pc"},    bus.ex_pc_out, got.pc);
    chk({tag, "_r1"},    bus.ex_rdata1_out, got.r1);
    chk({tag, "_r2"},    bus.ex_rdata2_out, got.r2);
    chk({tag, "_imm"},   bus.ex_imm_out, got.imm);
    chk({tag, "_rs"},    {27'd0, bus.ex_rs_out}, {27'd0, got.rs});
    chk({tag, "_rt"},    {27'd0, bus.ex_rt_out}, {27'd0, got.rt});
    chk({tag, "_dest"},  {27'd0, bus.ex_dest_out}, {27'd0, got.dest});
    chk({tag, "_ctrl"},  {23'd0, bus.ex_ctrl_out}, {23'd0, got.ctrl});
    chk({tag, "_cnt"},   {16'd0, bus.stall_count_out}, {16'd0, exp_cnt});
    chk({tag, "_cnt_s"}, {29'd0, bus_s.stall_count_out}, {29'd0, exp_cnt_s});
    m_ex = got;
  endtask

  logic [8:0] c_add, c_lw;

  initial begin
    c_add = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    c_lw  = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    m_ex = bubble(); exp_cnt = '0; exp_cnt_s = '0;
    bus.id_valid_in = 0; bus.id_pc_in = 0; bus.id_rdata1_in = 0; bus.id_rdata2_in = 0;
    bus.id_imm_in = 0; bus.id_rs_in = 0; bus.id_rt_in = 0; bus.id_rd_in = 0;
    bus.id_ctrl_in = 0; bus.flush_in = 0;
    bus.wb_reg_write_in = 0; bus.wb_write_reg_in = 0; bus.wb_write_data_in = 0;

    repeat (2) @(posedge clk);
    #1 chk_reset_state("por");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // add $3,$1,$2
    step("pass", 1, 32'h4, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, c_add, 0, 0, 0, 0);
    // lw $4 then dependent add: one stall, bubble, then issue
    step("lw4",  1, 32'h8, 32'h10, 32'h0, 32'h4, 5'd1, 5'd4, 5'd0, c_lw, 0, 0, 0, 0);
    step("lu1",  1, 32'hC, 32'h0, 32'h7, 32'h0, 5'd4, 5'd2, 5'd5, c_add, 0, 0, 0, 0);
    step("lu1i", 1, 32'hC, 32'h0, 32'h7, 32'h0, 5'd4, 5'd2, 5'd5, c_add, 0, 0, 0, 0);
    // back-to-back dependent loads, hazard via rt on the second
    step("lw6",  1, 32'h10, 32'h1, 32'h0, 32'h8, 5'd1, 5'd6, 5'd0, c_lw, 0, 0, 0, 0);
    step("lw7",  1, 32'h14, 32'h2, 32'h0, 32'hC, 5'd6, 5'd7, 5'd0, c_lw, 0, 0, 0, 0);
    step("lw7i", 1, 32'h14, 32'h2, 32'h0, 32'hC, 5'd6, 5'd7, 5'd0, c_lw, 0, 0, 0, 0);
    step("rt7",  1, 32'h18, 32'h3, 32'h4, 32'h0, 5'd2, 5'd7, 5'd9, c_add, 0, 0, 0, 0);
    step("rt7i", 1, 32'h18, 32'h3, 32'h4, 32'h0, 5'd2, 5'd7, 5'd9, c_add, 0, 0, 0, 0);
    // flush overrides a simultaneous load-use
    step("lw8",  1, 32'h1C, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, c_lw, 0, 0, 0, 0);
    step("flsh", 1, 32'h20, 32'h9, 32'h9, 32'h0, 5'd8, 5'd2, 5'd3, c_add, 1, 0, 0, 0);
    // load to $zero never stalls; invalid ID never stalls
    step("lw0",  1, 32'h24, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, c_lw, 0, 0, 0, 0);
    step("zero", 1, 32'h28, 32'hA, 32'hB, 32'h0, 5'd0, 5'd0, 5'd3, c_add, 0, 0, 0, 0);
    step("lw10", 1, 32'h2C, 32'h0, 32'h0, 32'h0, 5'd1, 5'd10, 5'd0, c_lw, 0, 0, 0, 0);
    step("inv",  0, 32'h30, 32'h1, 32'h2, 32'h0, 5'd10, 5'd2, 5'd3, c_add, 0, 0, 0, 0);
    // WB bypass on rs; rt uses a different register so it is not bypassed
    step("byp",  1, 32'h34, 32'h1111, 32'h2222, 32'h0, 5'd5, 5'd6, 5'd7, c_add, 0,
         1, 5'd5, 32'hDEAD);
    step("byp0", 1, 32'h38, 32'h3333, 32'h4444, 32'h0, 5'd0, 5'd0, 5'd7, c_add, 0,
         1, 5'd0, 32'hBEEF);

    // repeated stalls: the 3-bit counter saturates at 7
    for (int i = 0; i < 10; i++) begin
      step("slw", 1, 32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 5'd11, 5'd0, c_lw, 0, 0, 0, 0);
      step("sst", 1, 32'h44, 32'h1, 32'h2, 32'h0, 5'd11, 5'd2, 5'd3, c_add, 0, 0, 0, 0);
      step("sis", 1, 32'h44, 32'h1, 32'h2, 32'h0, 5'd11, 5'd2, 5'd3, c_add, 0, 0, 0, 0);
    end

    // asynchronous reset in the middle of a stall cycle
    step("rlw", 1, 32'h48, 32'h0, 32'h0, 32'h0, 5'd1, 5'd12, 5'd0, c_lw, 0, 0, 0, 0);
    bus.id_rs_in = 5'd12; bus.id_rt_in = 5'd2; bus.id_ctrl_in = c_add; bus.id_valid_in = 1;
    #2;
    chk("pre_rst_stall", {31'd0, bus.stall_out}, 32'd1);
    rst = 1'b0;
    #1 chk_reset_state("mid_rst");
    @(negedge clk); rst = 1'b1;
    m_ex = bubble(); exp_cnt = '0; exp_cnt_s = '0;
    sb.delete();
    @(posedge clk); #1;
    step("post", 1, 32'h50, 32'h21, 32'h22, 32'h23, 5'd12, 5'd2, 5'd4, c_add, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the 32-bit MIPS pipeline. It latches the register-file read data (rdata1/rdata2), the decoded immediate, the register indices and the control bundle for the EX stage. It contains the load-use hazard detector, which generates the stall and bubble, and branch-flush handling. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
N, 32, datapath width
CTRL_W, 9, control bundle width (bit map in mips_pkg)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous reset, active-low
id_valid_in  in  1  ID stage holds a real instruction
id_pc_in  in  N  PC+4 of ID instruction
id_rdata1_in  in  N  register-file port 1 data (rs)
id_rdata2_in  in  N  register-file port 2 data (rt)
id_imm_in  in  N  sign-extended immediate
id_rs_in  in  5  rs index
id_rt_in  in  5  rt index
id_rd_in  in  5  rd index
id_ctrl_in  in  CTRL_W  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]}
flush_in  in  1  branch/jump taken in EX; squash ID instruction
wb_reg_write_in  in  1  WB write enable (bypass option only)
wb_write_reg_in  in  5  WB destination (bypass option only)
wb_write_data_in  in  N  WB data (bypass option only)
ex_valid_out  out  1  EX holds a real instruction
ex_pc_out  out  N
ex_rdata1_out  out  N
ex_rdata2_out  out  N
ex_imm_out  out  N
ex_rs_out  out  5
ex_rt_out  out  5
ex_dest_out  out  5  reg_dst ? rd : rt, resolved in ID
ex_ctrl_out  out  CTRL_W
stall_out  out  1  combinational; holds PC and IF/ID
stall_count_out  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, including stall_count_out. The register-file pair sees a bubble, so no writes occur.
- Load-use hazard: load_use = ex_valid_out & ex_ctrl_out.mem_read & (ex_dest_out != 0) & id_valid_in & ((ex_dest_out == id_rs_in) | (ex_dest_out == id_rt_in)).
- stall_out = load_use & ~flush_in. Purely combinational, with no register.
- On each posedge, evaluate in priority order:
  1. flush_in=1: load a bubble (valid=0, ctrl=0, dest=0; data fields don't-care, driven 0).
  2. Else if stall_out=1: load a bubble, and the external IF/ID holds.
  3. Else: load the ID fields, valid=id_valid_in, ctrl = id_valid_in ? id_ctrl_in : 0.
- Latency: one cycle, ID to EX.
- A load-use stall lasts exactly one cycle, because the inserted bubble clears the hazard next cycle. Back-to-back dependent loads each stall once.
- Destination index 0 never causes a stall. A flush overrides a simultaneous stall.
- stall_count_out increments when stall_out=1 at posedge and saturates at all-ones; it does not wrap.
- Reset asserted mid-stall clears outputs immediately. stall_out then reads 0 because ex_valid_out=0.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when wb_reg_write_in=1, wb_write_reg_in!=0 and wb_write_reg_in equals id_rs_in (or id_rt_in), the latched rdata1 (or rdata2) takes wb_write_data_in instead of register-file data. Each port is checked independently. This covers a same-cycle write/read in the register file.
- Not defined: the wb_* ports are present but ignored, and operands come only from id_rdata*_in.

Decomposition:
- mips_pkg: CTRL_W, the control bit-index constants (CTRL_REG_WRITE ... CTRL_ALU_OP), and a BUBBLE_CTRL zero constant.
- One sub-module, hazard_detect: purely combinational load_use / stall_out logic, instantiated once.
- Pipeline register, counter and bypass muxes stay in id_ex_stage.

Test Plan:
- Reset: drive rst=0 mid-run with outputs non-zero -> all outputs 0 asynchronously, stall_count_out=0.
- Pass-through: ID add $3,$1,$2 with rdata1=0x5, rdata2=0x7, reg_dst=1, rd=3 -> next cycle ex_rdata1=0x5, ex_rdata2=0x7, ex_dest=3, ex_valid=1, stall_out=0.
- Load-use: EX lw $4 (mem_read=1, dest=4), ID rs=4 -> stall_out=1 for exactly one cycle, the next EX is a bubble (valid=0, ctrl=0), the instruction then issues, and stall_count_out increments by 1.
- Flush over stall: load-use condition present together with flush_in=1 -> stall_out=0, bubble loaded, counter unchanged.
- $zero and saturation: EX lw $0 with ID rs=0 -> no stall. Preload the counter near max and force stalls -> stall_count_out holds at 0xFFFF.
- WB_BYPASS_EN: wb write $5=0xDEAD with ID rs=5, rdata1=0x1111 -> ex_rdata1=0xDEAD. With the macro undefined -> 0x1111.
